// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the GPU command blocks: draw FSM encoding, opcodes,
// and the index helpers used to pick and range-limit vertex/edge indices.
package gpu_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDGE_WAIT,
    ST_VTX_WAIT,
    ST_EMIT
  } draw_state_t;

  localparam logic [7:0] CMD_DRAW_TRI  = 8'h06;
  localparam logic [7:0] CMD_DRAW_PRIM = 8'h07;

  // Indices are widened by one bit so base+offset can exceed 16 bits without wrapping.
  localparam int IDX_EXT_W  = 17;
  localparam int EDGE_MAX_W = 256;

  function automatic logic [IDX_EXT_W-1:0] edge_field(
    input logic [EDGE_MAX_W-1:0] word,
    input int                    k,
    input int                    idx_w
  );
    logic [EDGE_MAX_W-1:0] sh;
    logic [IDX_EXT_W-1:0]  r;
    sh = word >> (k * idx_w);
    r  = '0;
    for (int b = 0; b < IDX_EXT_W; b++) begin
      if (b < idx_w) r[b] = sh[b];
    end
    return r;
  endfunction

  function automatic logic idx_oob(input logic [IDX_EXT_W-1:0] idx, input int depth);
    return idx >= IDX_EXT_W'(depth);
  endfunction

  function automatic logic [IDX_EXT_W-1:0] clamp_idx(input logic [IDX_EXT_W-1:0] idx,
                                                     input int depth);
    return idx_oob(idx, depth) ? IDX_EXT_W'(depth - 1) : idx;
  endfunction

endpackage

// File: rtl/cmd_rd_timer.sv
// RAM read-latency timer: start at the issuing edge, expire is high in the
// cycle before the edge where the read data must be sampled.
module cmd_rd_timer #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expire
);

  localparam int            CW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(RD_LAT - 1);

  logic          active;
  logic [CW-1:0] cnt;

  assign expire = active && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= LOAD;
    end else if (expire) begin
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cmd_draw_prim.sv
// Draw-primitive fetch: reads a run of edge records, gathers NVERT vertices per
// record and hands each assembled primitive to the rasterizer.
module cmd_draw_prim
  import gpu_cmd_pkg::*;
#(
  parameter  int DEPTH     = 1024,
  parameter  int DW_VERTEX = 64,
  parameter  int DW_EDGE   = 48,
  parameter  int NVERT     = 3,
  parameter  int IDX_W     = 16,
  parameter  int RD_LAT    = 2,
  parameter  int CNT_W     = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       draw_req_pulse,
  input  logic [15:0]                edge_addr,
  input  logic [CNT_W-1:0]           prim_count,
  input  logic [DW_EDGE-1:0]         edge_data,
  input  logic [DW_VERTEX-1:0]       vertex_data,
  output logic [ADDR_W-1:0]          ADDR_EDGE,
  output logic                       RD_EDGE,
  output logic [ADDR_W-1:0]          ADDR_VERTEX,
  output logic                       RD_VERTEX,
  output logic                       prim_valid,
  input  logic                       prim_ready,
  output logic [NVERT*DW_VERTEX-1:0] prim_data,
  output logic                       prim_last,
  output logic                       BUSY,
  output logic                       done_pulse,
  output logic                       ERR
);

  localparam logic [1:0] LAST_VK = 2'(NVERT - 1);

  draw_state_t state, state_next;

  logic [IDX_EXT_W-1:0] edge_pos;
  logic [CNT_W-1:0]     remaining;
  logic [DW_EDGE-1:0]   edge_reg;
  logic [1:0]           vk;

  logic accept, issue_edge, issue_vtx, latch_edge, capture, finish, handshake;
  logic tmr_expire;

  logic [IDX_EXT_W-1:0] edge_req_pos;
  logic [IDX_EXT_W-1:0] vtx_idx;
  logic [DW_EDGE-1:0]   vtx_src;
  logic [1:0]           vtx_sel;

  cmd_rd_timer #(.RD_LAT(RD_LAT)) u_timer (
    .clk    (CLK),
    .rst    (rst),
    .start  (issue_edge || issue_vtx),
    .expire (tmr_expire)
  );

  assign prim_valid = (state == ST_EMIT);
  assign BUSY       = (state != ST_IDLE);
  assign handshake  = prim_valid && prim_ready;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue_edge = 1'b0;
    issue_vtx  = 1'b0;
    latch_edge = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (draw_req_pulse && (prim_count != '0)) begin
          accept     = 1'b1;
          issue_edge = 1'b1;
          state_next = ST_EDGE_WAIT;
        end
      end
      ST_EDGE_WAIT: begin
        if (tmr_expire) begin
          latch_edge = 1'b1;
          issue_vtx  = 1'b1;
          state_next = ST_VTX_WAIT;
        end
      end
      ST_VTX_WAIT: begin
        if (tmr_expire) begin
          capture = 1'b1;
          if (vk == LAST_VK) state_next = ST_EMIT;
          else               issue_vtx  = 1'b1;
        end
      end
      ST_EMIT: begin
        if (handshake) begin
          if (remaining == CNT_W'(1)) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            issue_edge = 1'b1;
            state_next = ST_EDGE_WAIT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Vertex 0 is steered from the live edge word, later vertices from the latched copy.
  always_comb begin
    edge_req_pos = accept ? IDX_EXT_W'(edge_addr) : edge_pos + 1'b1;
    vtx_sel      = (state == ST_EDGE_WAIT) ? 2'd0 : vk + 2'd1;
    vtx_src      = (state == ST_EDGE_WAIT) ? edge_data : edge_reg;
    vtx_idx      = edge_field(EDGE_MAX_W'(vtx_src), int'(vtx_sel), IDX_W);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ADDR_EDGE   <= '0;
      RD_EDGE     <= 1'b0;
      ADDR_VERTEX <= '0;
      RD_VERTEX   <= 1'b0;
      prim_data   <= '0;
      prim_last   <= 1'b0;
      done_pulse  <= 1'b0;
      ERR         <= 1'b0;
      edge_pos    <= '0;
      remaining   <= '0;
      edge_reg    <= '0;
      vk          <= '0;
    end else begin
      RD_EDGE    <= issue_edge;
      RD_VERTEX  <= issue_vtx;
      done_pulse <= finish;

      if (accept)                 remaining <= prim_count;
      else if (issue_edge)        remaining <= remaining - 1'b1;

      if (issue_edge) begin
        edge_pos  <= edge_req_pos;
        ADDR_EDGE <= ADDR_W'(clamp_idx(edge_req_pos, DEPTH));
      end

      if (latch_edge) begin
        edge_reg <= edge_data;
        vk       <= '0;
      end

      if (issue_vtx) ADDR_VERTEX <= ADDR_W'(clamp_idx(vtx_idx, DEPTH));

      if (capture) begin
        prim_data[int'(vk)*DW_VERTEX +: DW_VERTEX] <= vertex_data;
        if (issue_vtx) vk        <= vk + 2'd1;
        else           prim_last <= (remaining == CNT_W'(1));
      end

      if (handshake) prim_last <= 1'b0;

      // Range errors are sticky for the batch; a newly accepted request starts clean.
      if (accept)
        ERR <= idx_oob(edge_req_pos, DEPTH);
      else if ((issue_edge && idx_oob(edge_req_pos, DEPTH)) ||
               (issue_vtx && idx_oob(vtx_idx, DEPTH)))
        ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_draw_prim.sv
// Directed bench for cmd_draw_prim: a triangle/RD_LAT=2 instance and a
// quad/RD_LAT=1 instance driven from one linear stimulus sequence.
module tb_cmd_draw_prim;

  localparam int DEPTH = 1024;
  localparam int W     = 256;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  // Instance A: NVERT=3, RD_LAT=2
  logic         a_req, a_ready;
  logic [15:0]  a_addr;
  logic [7:0]   a_cnt;
  logic [47:0]  a_edata;
  logic [63:0]  a_vdata;
  logic [9:0]   a_addr_edge, a_addr_vtx;
  logic         a_rd_edge, a_rd_vtx, a_valid, a_last, a_busy, a_done, a_err;
  logic [191:0] a_prim;

  // Instance B: NVERT=4, RD_LAT=1
  logic         b_req, b_ready;
  logic [15:0]  b_addr;
  logic [7:0]   b_cnt;
  logic [63:0]  b_edata;
  logic [63:0]  b_vdata;
  logic [9:0]   b_addr_edge, b_addr_vtx;
  logic         b_rd_edge, b_rd_vtx, b_valid, b_last, b_busy, b_done, b_err;
  logic [255:0] b_prim;

  cmd_draw_prim #(.DEPTH(DEPTH), .DW_VERTEX(64), .DW_EDGE(48), .NVERT(3), .IDX_W(16),
                  .RD_LAT(2), .CNT_W(8)) u_dut_a (
    .CLK(CLK), .rst(rst), .draw_req_pulse(a_req), .edge_addr(a_addr), .prim_count(a_cnt),
    .edge_data(a_edata), .vertex_data(a_vdata), .ADDR_EDGE(a_addr_edge), .RD_EDGE(a_rd_edge),
    .ADDR_VERTEX(a_addr_vtx), .RD_VERTEX(a_rd_vtx), .prim_valid(a_valid), .prim_ready(a_ready),
    .prim_data(a_prim), .prim_last(a_last), .BUSY(a_busy), .done_pulse(a_done), .ERR(a_err)
  );

  cmd_draw_prim #(.DEPTH(DEPTH), .DW_VERTEX(64), .DW_EDGE(64), .NVERT(4), .IDX_W(16),
                  .RD_LAT(1), .CNT_W(8)) u_dut_b (
    .CLK(CLK), .rst(rst), .draw_req_pulse(b_req), .edge_addr(b_addr), .prim_count(b_cnt),
    .edge_data(b_edata), .vertex_data(b_vdata), .ADDR_EDGE(b_addr_edge), .RD_EDGE(b_rd_edge),
    .ADDR_VERTEX(b_addr_vtx), .RD_VERTEX(b_rd_vtx), .prim_valid(b_valid), .prim_ready(b_ready),
    .prim_data(b_prim), .prim_last(b_last), .BUSY(b_busy), .done_pulse(b_done), .ERR(b_err)
  );

  // RAM models. Latency 2: the strobed address is captured one edge after issue
  // and the read data is ready for the following edge. Latency 1: combinational read.
  logic [47:0] emem_a [DEPTH];
  logic [63:0] emem_b [DEPTH];
  logic [63:0] vmem   [DEPTH];
  logic [9:0]  a_eq, a_vq;

  always @(posedge CLK) begin
    if (a_rd_edge) a_eq <= a_addr_edge;
    if (a_rd_vtx)  a_vq <= a_addr_vtx;
  end
  assign a_edata = emem_a[a_eq];
  assign a_vdata = vmem[a_vq];
  assign b_edata = emem_b[b_addr_edge];
  assign b_vdata = vmem[b_addr_vtx];

  function automatic logic [63:0] vval(input int i);
    logic [31:0] iv;
    iv = i;
    return {16'hBEEF, iv[15:0], iv * 32'd7 + 32'd1};
  endfunction

  function automatic logic [47:0] tri3(input int f0, input int f1, input int f2);
    logic [15:0] x0, x1, x2;
    x0 = 16'(f0);
    x1 = 16'(f1);
    x2 = 16'(f2);
    return {x2, x1, x0};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic req_a(input int addr, input int cnt);
    a_req  = 1'b1;
    a_addr = 16'(addr);
    a_cnt  = 8'(cnt);
    step(1);
    a_req  = 1'b0;
  endtask

  initial begin
    logic [191:0] held;
    int           dcount;

    rst = 1'b1;
    a_req = 1'b0; a_ready = 1'b0; a_addr = '0; a_cnt = '0;
    b_req = 1'b0; b_ready = 1'b0; b_addr = '0; b_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vmem[i]   = vval(i);
      emem_a[i] = '0;
      emem_b[i] = '0;
    end
    emem_a[5]    = tri3(2, 7, 9);
    emem_a[10]   = tri3(1, 2, 3);
    emem_a[11]   = tri3(4, 5, 6);
    emem_a[20]   = tri3(5, 16'h0500, 8);
    emem_a[1023] = tri3(1, 2, 3);
    emem_b[3]    = {16'd13, 16'd12, 16'd11, 16'd10};

    #12;
    check("rst_busy",  W'(a_busy),      W'(0));
    check("rst_valid", W'(a_valid),     W'(0));
    check("rst_rd",    W'(a_rd_edge),   W'(0));
    check("rst_err",   W'(a_err),       W'(0));
    check("rst_addr",  W'(a_addr_edge), W'(0));
    check("rst_done",  W'(a_done),      W'(0));
    rst = 1'b0;
    step(1);

    // Single triangle, ready held high.
    a_ready = 1'b1;
    req_a(5, 1);
    check("t1_rd_edge",   W'(a_rd_edge),   W'(1));
    check("t1_addr_edge", W'(a_addr_edge), W'(5));
    check("t1_busy",      W'(a_busy),      W'(1));
    step(1);
    check("t1_rd_edge_1cyc", W'(a_rd_edge), W'(0));
    step(1);
    check("t1_rd_v0",  W'(a_rd_vtx),   W'(1));
    check("t1_addr_v0", W'(a_addr_vtx), W'(2));
    step(1);
    check("t1_rd_v0_1cyc", W'(a_rd_vtx), W'(0));
    step(1);
    check("t1_addr_v1", W'(a_addr_vtx), W'(7));
    step(2);
    check("t1_addr_v2", W'(a_addr_vtx), W'(9));
    step(1);
    check("t1_valid_early", W'(a_valid), W'(0));
    step(1);
    check("t1_valid", W'(a_valid), W'(1));
    check("t1_last",  W'(a_last),  W'(1));
    check("t1_data",  W'(a_prim),  W'({vval(9), vval(7), vval(2)}));
    step(1);
    check("t1_valid_drop", W'(a_valid), W'(0));
    check("t1_done",       W'(a_done),  W'(1));
    check("t1_busy_drop",  W'(a_busy),  W'(0));
    step(1);
    check("t1_done_pulse", W'(a_done), W'(0));

    // Two primitives with back-pressure.
    a_ready = 1'b0;
    req_a(10, 2);
    check("t2_addr_edge0", W'(a_addr_edge), W'(10));
    step(8);
    check("t2_valid0", W'(a_valid), W'(1));
    check("t2_last0",  W'(a_last),  W'(0));
    held = {vval(3), vval(2), vval(1)};
    check("t2_data0",  W'(a_prim),  W'(held));
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t2_hold_valid", W'(a_valid),     W'(1));
      check("t2_hold_data",  W'(a_prim),      W'(held));
      check("t2_hold_rd",    W'(a_rd_edge),   W'(0));
      check("t2_hold_addr",  W'(a_addr_edge), W'(10));
    end
    a_ready = 1'b1;
    step(1);
    check("t2_hs_valid", W'(a_valid),     W'(0));
    check("t2_hs_rd",    W'(a_rd_edge),   W'(1));
    check("t2_hs_addr",  W'(a_addr_edge), W'(11));
    check("t2_hs_done",  W'(a_done),      W'(0));
    step(8);
    check("t2_valid1", W'(a_valid), W'(1));
    check("t2_last1",  W'(a_last),  W'(1));
    check("t2_data1",  W'(a_prim),  W'({vval(6), vval(5), vval(4)}));
    step(1);
    check("t2_done", W'(a_done), W'(1));

    // Out-of-range vertex index is clamped and flagged; batch continues.
    req_a(20, 1);
    check("t3_err_clear", W'(a_err), W'(0));
    step(4);
    check("t3_addr_clamp", W'(a_addr_vtx), W'(1023));
    check("t3_err_set",    W'(a_err),      W'(1));
    step(4);
    check("t3_valid", W'(a_valid), W'(1));
    check("t3_data",  W'(a_prim),  W'({vval(8), vval(1023), vval(5)}));
    step(1);
    check("t3_done",       W'(a_done), W'(1));
    check("t3_err_sticky", W'(a_err),  W'(1));
    req_a(5, 1);
    check("t3_err_new_req", W'(a_err), W'(0));
    step(9);
    check("t3_done2", W'(a_done), W'(1));

    // Edge index overflow past the last record, plus ignored requests.
    req_a(1023, 2);
    check("t4_addr_edge0", W'(a_addr_edge), W'(1023));
    check("t4_err0",       W'(a_err),       W'(0));
    step(2);
    a_req = 1'b1; a_addr = 16'd5; a_cnt = 8'd1;
    step(1);
    a_req = 1'b0;
    check("t4_busy_req_addr", W'(a_addr_edge), W'(1023));
    check("t4_busy_req_rd",   W'(a_rd_edge),   W'(0));
    check("t4_busy_req_vtx",  W'(a_addr_vtx),  W'(1));
    step(5);
    check("t4_valid0", W'(a_valid), W'(1));
    check("t4_last0",  W'(a_last),  W'(0));
    check("t4_err_pre", W'(a_err),  W'(0));
    step(1);
    check("t4_rd_edge1",   W'(a_rd_edge),   W'(1));
    check("t4_addr_clamp", W'(a_addr_edge), W'(1023));
    check("t4_err_set",    W'(a_err),       W'(1));
    step(8);
    check("t4_valid1", W'(a_valid), W'(1));
    check("t4_last1",  W'(a_last),  W'(1));
    check("t4_data1",  W'(a_prim),  W'({vval(3), vval(2), vval(1)}));
    step(1);
    check("t4_done", W'(a_done), W'(1));
    check("t4_idle", W'(a_busy), W'(0));
    a_req = 1'b1; a_addr = 16'd7; a_cnt = 8'd0;
    step(1);
    a_req = 1'b0;
    check("t4_zero_busy", W'(a_busy),      W'(0));
    check("t4_zero_rd",   W'(a_rd_edge),   W'(0));
    check("t4_zero_addr", W'(a_addr_edge), W'(1023));
    check("t4_zero_err",  W'(a_err),       W'(1));

    // Asynchronous reset in VTX_WAIT.
    req_a(5, 1);
    step(3);
    check("t5_pre_addr_v", W'(a_addr_vtx), W'(2));
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_busy",   W'(a_busy),      W'(0));
    check("t5_rst_addr_e", W'(a_addr_edge), W'(0));
    check("t5_rst_addr_v", W'(a_addr_vtx),  W'(0));
    check("t5_rst_valid",  W'(a_valid),     W'(0));
    check("t5_rst_err",    W'(a_err),       W'(0));
    check("t5_rst_data",   W'(a_prim),      W'(0));
    #2;
    rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      step(1);
      if (a_done) dcount++;
    end
    check("t5_no_done", W'(dcount), W'(0));
    req_a(5, 1);
    step(8);
    check("t5_valid", W'(a_valid), W'(1));
    check("t5_data",  W'(a_prim),  W'({vval(9), vval(7), vval(2)}));
    step(1);
    check("t5_done", W'(a_done), W'(1));

    // Quad with single-cycle read latency.
    b_ready = 1'b1;
    b_req = 1'b1; b_addr = 16'd3; b_cnt = 8'd1;
    step(1);
    b_req = 1'b0;
    check("t6_rd_edge",   W'(b_rd_edge),   W'(1));
    check("t6_addr_edge", W'(b_addr_edge), W'(3));
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("t6_rd_vtx",   W'(b_rd_vtx),   W'(1));
      check("t6_addr_vtx", W'(b_addr_vtx), W'(10 + k));
      check("t6_no_valid", W'(b_valid),    W'(0));
    end
    step(1);
    check("t6_valid", W'(b_valid), W'(1));
    check("t6_last",  W'(b_last),  W'(1));
    check("t6_data",  W'(b_prim),  W'({vval(13), vval(12), vval(11), vval(10)}));
    step(1);
    check("t6_done", W'(b_done), W'(1));
    check("t6_busy", W'(b_busy), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
